// File: rtl/rvvi_frame_scheduler_if.sv
// rvvi_frame_scheduler_if: trace-record input, 32-bit stream output and status of the RVVI frame scheduler
interface rvvi_frame_scheduler_if #(parameter int RECORD_BITS = 792);
  logic                   RecordValid;
  logic [RECORD_BITS-1:0] Record;
  logic                   ExternalStall;
  logic [31:0]            RvviAxiWdata;
  logic [3:0]             RvviAxiWstrb;
  logic                   RvviAxiWlast;
  logic                   RvviAxiWvalid;
  logic                   RvviAxiWready;
  logic                   Busy;
  logic [31:0]            FrameCount;
  logic [15:0]            DropCount;
  modport master (
    input  RecordValid, Record, RvviAxiWready,
    output ExternalStall, RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast, RvviAxiWvalid,
           Busy, FrameCount, DropCount
  );
  modport slave (
    output RecordValid, Record, RvviAxiWready,
    input  ExternalStall, RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast, RvviAxiWvalid,
           Busy, FrameCount, DropCount
  );
endinterface

// File: rtl/rvvi_frame_scheduler.sv
// rvvi_frame_scheduler: buffers RVVI trace records and streams each one as an Ethernet frame
module rvvi_frame_scheduler #(
  parameter int          RECORD_BITS        = 792,
  parameter int          DEPTH              = 4,
  parameter logic [31:0] RVVI_INIT_TIME_OUT = 32'd4,
  parameter logic [31:0] RVVI_PACKET_DELAY  = 32'd2,
  parameter logic [47:0] DST_MAC            = 48'h8F54_0000_1654,
  parameter logic [47:0] SRC_MAC            = 48'h6A2F_0000_12A5,
  parameter logic [15:0] ETHERTYPE          = 16'h88B5
) (
  input logic                    clk,
  input logic                    reset,
  rvvi_frame_scheduler_if.master bus
);
  localparam int PW = (RECORD_BITS + 31) / 32;
  localparam int PB = PW * 32;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {INIT, IDLE, HEADER, PAYLOAD, GAP} state_t;
  state_t                 r_state, w_state_n;
  logic [31:0]            r_timer, w_timer_n;
  logic [15:0]            r_widx, w_widx_n;
  logic [RECORD_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [CW-1:0]          r_count, w_count_n;
  logic [15:0]            r_seq, r_drop;
  logic [31:0]            r_frames;
  logic                   r_stall;
  logic                   w_push, w_pop, w_valid, w_xfer, w_hdr_last, w_pay_last;
  logic [127:0]           w_hdr_be, w_hdr, w_hdr_sh;
  logic [PB-1:0]          w_pay, w_pay_sh;
  assign w_push     = bus.RecordValid && r_count != CW'(DEPTH);
  assign w_valid    = r_state == HEADER || r_state == PAYLOAD;
  assign w_xfer     = w_valid && bus.RvviAxiWready;
  assign w_hdr_last = r_widx == 16'd3;
  assign w_pay_last = r_widx == 16'(PW - 1);
  assign w_count_n  = r_count + CW'(w_push) - CW'(w_pop);
  // header is listed wire-order (first byte at the MSB) and reversed so byte 0 lands in Wdata[7:0]
  assign w_hdr_be   = {DST_MAC, SRC_MAC, ETHERTYPE, r_seq};
  assign w_pay      = PB'(r_mem[r_rptr]);
  assign w_hdr_sh   = w_hdr >> {r_widx[1:0], 5'd0};
  assign w_pay_sh   = w_pay >> {r_widx, 5'd0};
  always_comb begin
    w_hdr = '0;
    for (int k = 0; k < 16; k++) w_hdr[8*k +: 8] = w_hdr_be[127-8*k -: 8];
  end
  assign bus.RvviAxiWvalid = w_valid;
  assign bus.RvviAxiWstrb  = w_valid ? 4'hF : 4'h0;
  assign bus.RvviAxiWdata  = !w_valid ? 32'd0 : r_state == HEADER ? w_hdr_sh[31:0] : w_pay_sh[31:0];
  assign bus.RvviAxiWlast  = r_state == PAYLOAD && w_pay_last;
  assign bus.ExternalStall = r_stall;
  assign bus.Busy          = r_state != IDLE || r_count != '0;
  assign bus.FrameCount    = r_frames;
  assign bus.DropCount     = r_drop;
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_widx_n  = r_widx;
    w_pop     = 1'b0;
    case (r_state)
      INIT: begin
        w_state_n = r_timer == RVVI_INIT_TIME_OUT ? IDLE : INIT;
        w_timer_n = r_timer == RVVI_INIT_TIME_OUT ? 32'd0 : r_timer + 32'd1;
      end
      IDLE: begin
        w_state_n = r_count != '0 ? HEADER : IDLE;
        w_widx_n  = 16'd0;
      end
      HEADER: if (w_xfer) begin
        w_state_n = w_hdr_last ? PAYLOAD : HEADER;
        w_widx_n  = w_hdr_last ? 16'd0 : r_widx + 16'd1;
      end
      PAYLOAD: if (w_xfer) begin
        w_pop     = w_pay_last;
        w_state_n = !w_pay_last ? PAYLOAD : RVVI_PACKET_DELAY == 32'd0 ? IDLE : GAP;
        w_widx_n  = w_pay_last ? 16'd0 : r_widx + 16'd1;
        w_timer_n = 32'd0;
      end
      GAP: begin
        w_state_n = r_timer == RVVI_PACKET_DELAY - 32'd1 ? IDLE : GAP;
        w_timer_n = r_timer == RVVI_PACKET_DELAY - 32'd1 ? 32'd0 : r_timer + 32'd1;
      end
      default: w_state_n = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= INIT;
      r_timer  <= '0;
      r_widx   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_frames <= '0;
      r_drop   <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_widx  <= w_widx_n;
      r_count <= w_count_n;
      r_stall <= w_count_n >= CW'(DEPTH - 1);
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr   <= r_rptr + AW'(1);
        r_seq    <= r_seq + 16'd1;
        r_frames <= r_frames + 32'd1;
      end
      if (bus.RecordValid && !w_push && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wptr] <= bus.Record;
endmodule
